// File: rtl/e_mdu.sv
// ----------------------------------------------------------------------------
// e_mdu -- E-stage multiply/divide unit
//
// Computes mult/multu/div/divu results from the forwarded A/B operands in a
// single step, parks the 64-bit result in pending registers and commits it to
// the architectural HI/LO registers only when a busy down-counter reaches its
// terminal count. The hazard unit uses busy to stall D-stage HI/LO readers.
// mthi/mtlo write HI/LO directly with single-cycle latency.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous, active-high; clears all state
//   A       in  32   forwarded rs operand
//   B       in  32   forwarded rt operand
//   md_op   in   4   0=none 1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo
//                    7=madd 8=maddu (only with MDU_MADD_EN)
//   cancel  in   1   squash this cycle's md_op (no issue, no write)
//   busy    out  1   registered; high while a mult/div is in flight
//   HI      out 32   architectural HI register
//   LO      out 32   architectural LO register
//
// Build option:
//   MDU_MADD_EN  when defined, madd/maddu accumulate A*B into {HI,LO}.
//                When undefined, codes 7/8 are no-ops and no adder is built.
//
// States:
//   ST_IDLE | no operation in flight; issue and mthi/mtlo accepted
//   ST_BUSY | pending result held, counter running down to commit
// ----------------------------------------------------------------------------
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  md_op,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        phi_q;
    logic [31:0]        plo_q;
    logic               busy_q;

    logic               is_mult;
    logic               is_div;
    logic               issue;
    logic [CNT_W-1:0]   cnt_d;
    logic [31:0]        phi_d;
    logic [31:0]        plo_d;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
`ifdef MDU_MADD_EN
    logic [63:0]        acc_s;
    logic [63:0]        acc_u;
`endif

    // Datapath: all results are formed combinationally from A/B; the busy
    // counter only models latency, the answer is ready at the issuing edge.
    always_comb begin
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'd0, A} * {32'd0, B};
        // Substitute 1 for a zero divisor so the divider never sees /0;
        // a zero-divisor div/divu is never issued anyway.
        divisor = (B == 32'd0) ? 32'd1 : B;
        quot_s  = $signed(A) / $signed(divisor);
        rem_s   = $signed(A) % $signed(divisor);
        quot_u  = A / divisor;
        rem_u   = A % divisor;
`ifdef MDU_MADD_EN
        acc_s   = {hi_q, lo_q} + prod_s;
        acc_u   = {hi_q, lo_q} + prod_u;
`endif
    end

    always_comb begin
        is_mult = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mult = is_mult || (md_op == OP_MADD) || (md_op == OP_MADDU);
`endif
        is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
        issue   = (state_q == ST_IDLE) && !cancel &&
                  (is_mult || (is_div && (B != 32'd0)));
        cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

        phi_d = 32'd0;
        plo_d = 32'd0;
        case (md_op)
            OP_MULT:  {phi_d, plo_d} = prod_s;
            OP_MULTU: {phi_d, plo_d} = prod_u;
            OP_DIV:   begin phi_d = rem_s; plo_d = quot_s; end
            OP_DIVU:  begin phi_d = rem_u; plo_d = quot_u; end
`ifdef MDU_MADD_EN
            OP_MADD:  {phi_d, plo_d} = acc_s;
            OP_MADDU: {phi_d, plo_d} = acc_u;
`endif
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        phi_q   <= phi_d;
                        plo_q   <= plo_d;
                        cnt_q   <= cnt_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end else if (!cancel) begin
                        if (md_op == OP_MTHI) hi_q <= A;
                        if (md_op == OP_MTLO) lo_q <= A;
                    end
                end
                ST_BUSY: begin
                    // New requests are ignored here; the hazard unit keeps
                    // md_op at zero while busy is high.
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= phi_q;
                        lo_q    <= plo_q;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  md_op;
    logic        cancel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    // Reference architectural state
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .md_op  (md_op),
        .cancel (cancel),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The hazard contract: no md_op may reach the unit while busy.
    always @(posedge clk) begin
        if (!reset && busy && md_op != 4'd0) begin
            bad = bad + 1;
            $display("FAIL md_op_while_busy: md_op=%0d busy=%0b required md_op=0", md_op, busy);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one op for one cycle, then count the cycles busy is seen high,
    // checking HI/LO hold their pre-issue values throughout.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic c, output int cyc);
        logic [31:0] hi0;
        logic [31:0] lo0;
        @(negedge clk);
        hi0 = HI;
        lo0 = LO;
        md_op = op; A = a; B = b; cancel = c;
        @(negedge clk);
        md_op = 4'd0; A = 32'd0; B = 32'd0; cancel = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            check("hold_hi", HI, hi0);
            check("hold_lo", LO, lo0);
            @(negedge clk);
        end
    endtask

    // Behavioural reference: plain arithmetic on the architectural state.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic c, output int cyc);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        up = {32'd0, a} * {32'd0, b};
        cyc = 0;
        if (!c) begin
            case (op)
                4'd1: begin {m_hi, m_lo} = sp; cyc = MC; end
                4'd2: begin {m_hi, m_lo} = up; cyc = MC; end
                4'd3: if (b != 0) begin m_lo = sa / sb; m_hi = sa % sb; cyc = DC; end
                4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; cyc = DC; end
                4'd5: m_hi = a;
                4'd6: m_lo = a;
                4'd7: if (MADD_EN) begin {m_hi, m_lo} = {m_hi, m_lo} + sp; cyc = MC; end
                4'd8: if (MADD_EN) begin {m_hi, m_lo} = {m_hi, m_lo} + up; cyc = MC; end
                default: ;
            endcase
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cyc;
        int mcyc;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;

        vecs[0] = '{4'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MC};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{4'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DC};
        vecs[4] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        vecs[5] = '{4'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MC};
        vecs[6] = '{4'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DC};
        vecs[7] = '{4'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, DC};

        reset = 1'b1; A = 32'd0; B = 32'd0; md_op = 4'd0; cancel = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset = 1'b0;

        // Directed arithmetic table
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, cyc);
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
            check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
        end

        // mthi then mtlo on consecutive cycles
        @(negedge clk);
        md_op = 4'd5; A = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", HI, 32'h12345678);
        md_op = 4'd6; A = 32'h9ABCDEF0;
        @(negedge clk);
        md_op = 4'd0; A = 32'd0;
        check("mtlo_lo", LO, 32'h9ABCDEF0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);

        // Cancelled mthi and cancelled mult
        do_op(4'd5, 32'hDEADBEEF, 32'd0, 1'b1, cyc);
        check("cancel_mthi_hi", HI, 32'h12345678);
        do_op(4'd1, 32'd3, 32'd3, 1'b1, cyc);
        check("cancel_mult_cycles", cyc, 0);
        check("cancel_mult_lo", LO, 32'h9ABCDEF0);

        // Divide by zero never issues
        do_op(4'd4, 32'd7, 32'd0, 1'b0, cyc);
        check("divu0_cycles", cyc, 0);
        check("divu0_hi", HI, 32'h12345678);
        check("divu0_lo", LO, 32'h9ABCDEF0);
        do_op(4'd3, 32'hFFFFFFF9, 32'd0, 1'b0, cyc);
        check("div0_cycles", cyc, 0);
        check("div0_lo", LO, 32'h9ABCDEF0);

        // Undefined codes
        do_op(4'd9, 32'h1, 32'h1, 1'b0, cyc);
        check("op9_hi", HI, 32'h12345678);
        do_op(4'd15, 32'h1, 32'h1, 1'b0, cyc);
        check("op15_lo", LO, 32'h9ABCDEF0);

        // Reset mid-divide: immediate clear, in-flight result abandoned
        @(negedge clk);
        md_op = 4'd3; A = 32'd100; B = 32'd3;
        @(negedge clk);
        md_op = 4'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_after_hi", HI, 32'd0);
        check("rst_after_lo", LO, 32'd0);
        check("rst_after_busy", {31'd0, busy}, 32'd0);

        // maddu accumulate across the 32-bit boundary
        do_op(4'd5, 32'h0, 32'd0, 1'b0, cyc);
        do_op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, cyc);
        do_op(4'd8, 32'd1, 32'd1, 1'b0, cyc);
        if (MADD_EN) begin
            check("maddu_cycles", cyc, MC);
            check("maddu_hi", HI, 32'h00000001);
            check("maddu_lo", LO, 32'h00000000);
        end else begin
            check("maddu_off_cycles", cyc, 0);
            check("maddu_off_hi", HI, 32'h00000000);
            check("maddu_off_lo", LO, 32'hFFFFFFFF);
        end

        // Randomised sequence against the reference model
        m_hi = HI;
        m_lo = LO;
        for (int n = 0; n < 150; n++) begin
            int r;
            r = $urandom_range(0, 9);
            op = (r == 9) ? 4'($urandom_range(9, 15)) : 4'(r);
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($signed($urandom_range(0, 16)) - 8);
                default: b = $urandom;
            endcase
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            c = ($urandom_range(0, 7) == 0);
            model_op(op, a, b, c, mcyc);
            do_op(op, a, b, c, cyc);
            check($sformatf("rnd%0d_op%0d_cycles", n, op), cyc, mcyc);
            check($sformatf("rnd%0d_op%0d_hi", n, op), HI, m_hi);
            check($sformatf("rnd%0d_op%0d_lo", n, op), LO, m_lo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- E-stage multiply/divide unit. Sits beside the E-stage ALU and consumes the same forwarded operands A/B.
- Its HI/LO outputs feed the E-stage result mux for mfhi/mflo.
- Models multi-cycle mult/div latency with a busy counter, so the hazard unit can stall D-stage HI/LO instructions.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a mult/multu issue (>=1)
- DIV_CYCLES, 10, cycles busy stays high after a div/divu issue (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- A  in  32  forwarded rs operand
- B  in  32  forwarded rt operand
- md_op  in  4  operation code; 0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=madd, 8=maddu (7/8 only with the optional feature)
- cancel  in  1  squash the E-stage instruction (exception/interrupt); the op in md_op this cycle is ignored
- busy  out  1  registered; high while a mult/div is in flight
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register

Behaviour:
- Reset (async, active-high): HI=0, LO=0, busy=0, counter=0, pending result=0. An in-flight operation is abandoned and never writes HI/LO.
- Issue condition: md_op in {1,2,3,4} (or {7,8} with the feature), busy=0, cancel=0.
- On the issuing edge:
  - Compute the 64-bit result from A/B and latch it into pending regs {phi,plo}.
  - Load counter with MULT_CYCLES (ops 1,2,7,8) or DIV_CYCLES (ops 3,4).
  - Set busy=1.
- Result arithmetic:
  - mult: {phi,plo} = signed A*B (64-bit).
  - multu: {phi,plo} = unsigned A*B.
  - div: plo = signed A/B, truncated toward zero; phi = signed A%B, sign follows the dividend.
  - divu: unsigned quotient/remainder.
  - B==0 for div/divu: no issue at all. HI/LO unchanged, busy stays 0.
- Countdown: each edge with busy=1 decrements the counter. On the edge where counter==1:
  - HI<=phi, LO<=plo, busy<=0.
  - Op issued at edge t0 therefore updates HI/LO and drops busy at edge t0+N.
- HI/LO outputs hold their old values throughout busy; the pending result is never visible early.
- mthi/mtlo: when busy=0 and cancel=0, HI<=A (mthi) or LO<=A (mtlo) on the same edge. Latency 1, no busy.
- Any md_op!=0 while busy=1 is ignored. The hazard unit guarantees this never happens; the bench asserts on it.
- Stall contract: the hazard unit stalls a D-stage HI/LO instruction when busy | (md_op in mult/div class). The block does not drive stall itself.
- cancel=1 blocks every write and every issue that cycle. cancel does not abort an in-flight op.
- Undefined md_op codes (9-15, or 7/8 without the feature): no-op.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: md_op 7 (madd) and 8 (maddu) are legal.
  - Result = {HI,LO} + signed (madd) or unsigned (maddu) A*B, mod 2^64.
  - Uses the HI/LO values at the issuing edge.
  - Latency MULT_CYCLES, same busy rules as mult.
- Undefined: codes 7/8 are no-ops and the accumulate adder is not built.

Test Plan:
- mult A=0xFFFFFFFF, B=0x00000002 -> busy high for exactly 5 cycles; at edge t0+5 HI=0xFFFFFFFF, LO=0xFFFFFFFE; HI/LO unchanged during busy.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> busy stays 0, HI/LO unchanged.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on the next cycle -> HI/LO update one edge after each; a mthi presented together with cancel=1 leaves HI unchanged.
- Issue div, assert reset at cycle 4 -> HI=LO=0, busy=0 immediately (async); no write at t0+10.
- MDU_MADD_EN: preset HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 -> HI=0x00000001, LO=0x00000000 after 5 cycles; without the macro the same op leaves HI/LO and busy unchanged.
